// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sensor conditioner and the light controller:
// channel state encoding, internal counter width and default timing constants.
package traffic_pkg;

   localparam int TS_CNT_W                = 32;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEFAULT_HOLD_CYCLES     = 50_000_000;
   localparam int DEFAULT_ARR_CNT_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_QUAL_ON  = 3'd1,
      ST_ACTIVE   = 3'd2,
      ST_QUAL_OFF = 3'd3,
      ST_HOLD     = 3'd4
   } sensor_state_e;

   // Traffic is reported in every state from ACTIVE through the end of HOLD.
   function automatic logic traffic_of(input sensor_state_e st);
      return (st == ST_ACTIVE) || (st == ST_QUAL_OFF) || (st == ST_HOLD);
   endfunction

endpackage

// File: rtl/sensor_channel.sv
// One detector channel: 2-flop synchronizer, debounce/hold FSM with a registered
// traffic flag, arrival pulse and saturating arrival counter.
module sensor_channel
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int CNT_W           = DEFAULT_ARR_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_raw,
   input  logic             i_clr_cnt,
   output logic             o_traffic,
   output logic             o_arr,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [TS_CNT_W-1:0] DEB_LAST  = TS_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TS_CNT_W-1:0] HOLD_LAST = TS_CNT_W'(HOLD_CYCLES - 1);

   logic [1:0]          r_sync;
   sensor_state_e       r_state;
   logic [TS_CNT_W-1:0] r_cnt;
   logic                r_traffic;
   logic                r_arr;
   logic [CNT_W-1:0]    r_arr_cnt;
   logic                w_s;

   assign w_s = r_sync[1];

   // r_traffic is written only on the transitions that change traffic_of(state),
   // so it always equals the decode of r_state without a combinational path.
   // NOTE: all state here is sequential, so every assignment below is non-blocking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync    <= '0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_traffic <= 1'b0;
         r_arr     <= 1'b0;
         r_arr_cnt <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         r_arr  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     r_state   <= ST_ACTIVE;
                     r_traffic <= 1'b1;
                     r_arr     <= 1'b1;
                  end else begin
                     r_state <= ST_QUAL_ON;
                     r_cnt   <= 32'd1;
                  end
               end
            end
            ST_QUAL_ON: begin
               if (!w_s) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == DEB_LAST) begin
                  r_state   <= ST_ACTIVE;
                  r_traffic <= 1'b1;
                  r_arr     <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            ST_ACTIVE: begin
               if (!w_s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     r_state <= ST_HOLD;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= ST_QUAL_OFF;
                     r_cnt   <= 32'd1;
                  end
               end
            end
            ST_QUAL_OFF: begin
               if (w_s) begin
                  r_state <= ST_ACTIVE;
               end else if (r_cnt == DEB_LAST) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            ST_HOLD: begin
               // A returning car cancels the hold without counting as a new arrival.
               if (w_s) begin
                  r_state <= ST_ACTIVE;
               end else if (r_cnt == HOLD_LAST) begin
                  r_state   <= ST_IDLE;
                  r_traffic <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_traffic <= 1'b0;
            end
         endcase

         if (i_clr_cnt) begin
            r_arr_cnt <= '0;
         end else if (r_arr && (r_arr_cnt != '1)) begin
            r_arr_cnt <= r_arr_cnt + 1'b1;
         end
      end
   end

   assign o_traffic = r_traffic;
   assign o_arr     = r_arr;
   assign o_cnt     = r_arr_cnt;

endmodule

// File: rtl/traffic_sensor_cond.sv
// Two independent car-detector conditioners (streets A and B) feeding the light
// controller's Ta/Tb inputs; this level only routes ports and shares clr_cnt.
module traffic_sensor_cond
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int CNT_W           = DEFAULT_ARR_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             senA,
   input  logic             senB,
   input  logic             clr_cnt,
   output logic             Ta,
   output logic             Tb,
   output logic             arrA,
   output logic             arrB,
   output logic [CNT_W-1:0] cntA,
   output logic [CNT_W-1:0] cntB
);

   sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan_a (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (senA),
      .i_clr_cnt (clr_cnt),
      .o_traffic (Ta),
      .o_arr     (arrA),
      .o_cnt     (cntA)
   );

   sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan_b (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (senB),
      .i_clr_cnt (clr_cnt),
      .o_traffic (Tb),
      .o_arr     (arrB),
      .o_cnt     (cntB)
   );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Bench for traffic_sensor_cond: a debounced-level plus hold-timer model checked
// every cycle, and directed scenarios with hand-computed literal expectations.
module tb_traffic_sensor_cond;

   localparam int D     = 4;
   localparam int H     = 8;
   localparam int W     = 8;
   localparam int CMAX  = (1 << W) - 1;

   logic         clk     = 1'b0;
   logic         reset   = 1'b1;
   logic         senA    = 1'b0;
   logic         senB    = 1'b0;
   logic         clr_cnt = 1'b0;
   logic         Ta, Tb, arrA, arrB;
   logic [W-1:0] cntA, cntB;

   traffic_sensor_cond #(
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .CNT_W           (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .senA    (senA),
      .senB    (senB),
      .clr_cnt (clr_cnt),
      .Ta      (Ta),
      .Tb      (Tb),
      .arrA    (arrA),
      .arrB    (arrB),
      .cntA    (cntA),
      .cntB    (cntB)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: the accepted (debounced) level flips after D consecutive disagreeing
   // synchronized samples; after a release the flag lingers for H more edges,
   // and any car seen during that linger restores the level without an arrival.
   bit m_s1[2], m_s2[2], m_deb[2], m_arr[2];
   int m_run[2], m_hold[2], m_cnt[2];

   task automatic model_chan(input int ch, input bit raw);
      bit s, new_arr;
      if (reset) begin
         m_s1[ch] = 0; m_s2[ch] = 0; m_deb[ch] = 0; m_arr[ch] = 0;
         m_run[ch] = 0; m_hold[ch] = 0; m_cnt[ch] = 0;
         return;
      end
      s = m_s2[ch];
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = raw;
      new_arr = 0;
      if (m_deb[ch]) begin
         if (!s) begin
            m_run[ch]++;
            if (m_run[ch] == D) begin
               m_deb[ch] = 0; m_run[ch] = 0; m_hold[ch] = H;
            end
         end else m_run[ch] = 0;
      end else if (m_hold[ch] > 0) begin
         if (s) begin
            m_deb[ch] = 1; m_hold[ch] = 0;
         end else m_hold[ch]--;
      end else begin
         if (s) begin
            m_run[ch]++;
            if (m_run[ch] == D) begin
               m_deb[ch] = 1; m_run[ch] = 0; new_arr = 1;
            end
         end else m_run[ch] = 0;
      end
      if (clr_cnt) m_cnt[ch] = 0;
      else if (m_arr[ch] && m_cnt[ch] < CMAX) m_cnt[ch]++;
      m_arr[ch] = new_arr;
   endtask

   always @(posedge clk) begin
      model_chan(0, senA);
      model_chan(1, senB);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_Ta",   Ta,   (m_deb[0] || m_hold[0] > 0) ? 1 : 0);
         check("model_Tb",   Tb,   (m_deb[1] || m_hold[1] > 0) ? 1 : 0);
         check("model_arrA", arrA, m_arr[0]);
         check("model_arrB", arrB, m_arr[1]);
         check("model_cntA", cntA, m_cnt[0]);
         check("model_cntB", cntB, m_cnt[1]);
      end
   end

   initial begin
      reset = 1'b1;
      tick(1);
      cmp_en = 1'b1;
      check("rst_Ta", Ta, 0);
      check("rst_Tb", Tb, 0);
      check("rst_cntA", cntA, 0);
      tick(1);
      reset = 1'b0;

      // A rises on the 6th edge with one arrival; B untouched.
      senA = 1'b1;
      tick(5);
      check("rise_Ta_edge5", Ta, 0);
      tick(1);
      check("rise_Ta_edge6", Ta, 1);
      check("rise_arrA", arrA, 1);
      check("rise_Tb", Tb, 0);
      tick(1);
      check("rise_arrA_gone", arrA, 0);
      check("rise_cntA", cntA, 1);
      check("rise_cntB", cntB, 0);
      check("rise_arrB", arrB, 0);

      // Release: Ta falls on the 14th edge.
      senA = 1'b0;
      tick(13);
      check("fall_Ta_edge13", Ta, 1);
      tick(1);
      check("fall_Ta_edge14", Ta, 0);

      // Second arrival, then a 2-edge dropout that must not register.
      senA = 1'b1;
      tick(6);
      check("rise2_Ta", Ta, 1);
      tick(1);
      check("rise2_cntA", cntA, 2);
      senA = 1'b0;
      tick(2);
      senA = 1'b1;
      tick(12);
      check("dropout_Ta", Ta, 1);
      check("dropout_cntA", cntA, 2);

      // Short 3-edge pulse from idle is ignored.
      senA = 1'b0;
      tick(20);
      check("idle_Ta", Ta, 0);
      senA = 1'b1;
      tick(3);
      senA = 1'b0;
      tick(12);
      check("short_Ta", Ta, 0);
      check("short_cntA", cntA, 2);

      // Car returns at edge 8 of the release, inside HOLD.
      senA = 1'b1;
      tick(7);
      check("rise3_cntA", cntA, 3);
      senA = 1'b0;
      tick(7);
      senA = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("hold_reassert_Ta", Ta, 1);
      end
      check("hold_reassert_cntA", cntA, 3);

      // 260 arrivals on B saturate its counter.
      for (int i = 0; i < 260; i++) begin
         senB = 1'b1;
         tick(7);
         senB = 1'b0;
         tick(15);
      end
      check("sat_cntB", cntB, CMAX);
      senB = 1'b1;
      tick(6);
      check("clr_arrB", arrB, 1);
      clr_cnt = 1'b1;
      tick(1);
      clr_cnt = 1'b0;
      check("clr_cntB", cntB, 0);
      check("clr_cntA", cntA, 0);

      // Reset with A in QUAL_ON and B in HOLD.
      senA = 1'b0;
      senB = 1'b0;
      tick(20);
      senB = 1'b1;
      tick(8);
      senB = 1'b0;
      tick(4);
      senA = 1'b1;
      tick(4);
      check("pre_rst_Tb", Tb, 1);
      reset = 1'b1;
      tick(1);
      check("mid_rst_Ta", Ta, 0);
      check("mid_rst_Tb", Tb, 0);
      check("mid_rst_arrA", arrA, 0);
      check("mid_rst_arrB", arrB, 0);
      check("mid_rst_cntA", cntA, 0);
      check("mid_rst_cntB", cntB, 0);
      reset = 1'b0;
      tick(5);
      check("post_rst_Ta_edge5", Ta, 0);
      tick(1);
      check("post_rst_Ta_edge6", Ta, 1);
      check("post_rst_Tb", Tb, 0);
      tick(2);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
